// File: rtl/rgb_pwm_capture_if.sv
// Signal bundle between the PWM capture block and its consumer: PWM lines and
// selector in, selected result and per-channel status out.
interface rgb_pwm_capture_if #(
   parameter int W = 16
);
   logic         red_in;
   logic         green_in;
   logic         blue_in;
   logic [1:0]   color_selector;
   logic [W-1:0] high_count;
   logic [W-1:0] period_count;
   logic [2:0]   sample_pulse;
   logic [2:0]   valid;
   logic [2:0]   stuck;
   logic [2:0]   stuck_level;

   modport master (
      output red_in, green_in, blue_in, color_selector,
      input  high_count, period_count, sample_pulse, valid, stuck, stuck_level
   );

   modport slave (
      input  red_in, green_in, blue_in, color_selector,
      output high_count, period_count, sample_pulse, valid, stuck, stuck_level
   );
endinterface

// File: rtl/rgb_pwm_capture.sv
// Three-channel PWM period/high-time capture with a selector mux on the results.
// Optional stuck-channel detection is enabled by defining PWM_CAPTURE_TIMEOUT_EN.
module rgb_pwm_capture #(
   parameter int R = 8,
   parameter int W = 16
`ifdef PWM_CAPTURE_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 2**(R+4)
`endif
) (
   input logic               clk,
   input logic               reset,
   rgb_pwm_capture_if.slave  bus
);
   localparam logic [W-1:0] SAT = '1;

`ifdef PWM_CAPTURE_TIMEOUT_EN
   localparam logic [W-1:0] TO_M1 = W'(TIMEOUT - 1);
   typedef enum logic [1:0] {ST_ARM, ST_MEASURE, ST_STUCK} state_t;
`else
   typedef enum logic [1:0] {ST_ARM, ST_MEASURE} state_t;
`endif

   if (W < R + 2) begin : g_w_too_narrow_for_r
   end

   logic [2:0]   pwm;
   logic [W-1:0] hi_arr  [3];
   logic [W-1:0] per_arr [3];
   logic [2:0]   pulse_v;
   logic [2:0]   valid_v;
`ifdef PWM_CAPTURE_TIMEOUT_EN
   logic [2:0]   stuck_v;
   logic [2:0]   stl_v;
`endif

   assign pwm = {bus.blue_in, bus.green_in, bus.red_in};

   for (genvar c = 0; c < 3; c++) begin : g_ch
      state_t       state_q, state_d;
      logic         s1_q, s2_q, hist_q, rise_q;
      logic [W-1:0] p_q, p_d, h_q, h_d;
      logic [W-1:0] per_q, per_d, hi_q, hi_d;
      logic         pulse_q, pulse_d, valid_q, valid_d;
`ifdef PWM_CAPTURE_TIMEOUT_EN
      logic         stuck_q, stuck_d, stl_q, stl_d;
      logic         timeout;
      assign timeout = (p_q == TO_M1) && !rise_q;
`endif

      // rise_q is registered so hist_q is the level aligned with it
      always_ff @(posedge clk) begin
         if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            hist_q  <= 1'b0;
            rise_q  <= 1'b0;
            state_q <= ST_ARM;
            p_q     <= '0;
            h_q     <= '0;
            per_q   <= '0;
            hi_q    <= '0;
            pulse_q <= 1'b0;
            valid_q <= 1'b0;
`ifdef PWM_CAPTURE_TIMEOUT_EN
            stuck_q <= 1'b0;
            stl_q   <= 1'b0;
`endif
         end else begin
            s1_q    <= pwm[c];
            s2_q    <= s1_q;
            hist_q  <= s2_q;
            rise_q  <= s2_q & ~hist_q;
            state_q <= state_d;
            p_q     <= p_d;
            h_q     <= h_d;
            per_q   <= per_d;
            hi_q    <= hi_d;
            pulse_q <= pulse_d;
            valid_q <= valid_d;
`ifdef PWM_CAPTURE_TIMEOUT_EN
            stuck_q <= stuck_d;
            stl_q   <= stl_d;
`endif
         end
      end

      always_comb begin
         state_d = state_q;
         per_d   = per_q;
         hi_d    = hi_q;
         pulse_d = 1'b0;
         valid_d = valid_q;
         p_d     = (p_q == SAT) ? p_q : p_q + 1'b1;
         h_d     = (hist_q && (h_q != SAT)) ? h_q + 1'b1 : h_q;
`ifdef PWM_CAPTURE_TIMEOUT_EN
         stuck_d = stuck_q;
         stl_d   = stl_q;
`endif
         if (rise_q) begin
            p_d = W'(1);
            h_d = W'(1);
         end
         case (state_q)
            ST_ARM: begin
               if (rise_q) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
               if (rise_q) begin
                  per_d   = p_q;
                  hi_d    = h_q;
                  pulse_d = 1'b1;
                  valid_d = 1'b1;
               end
            end
`ifdef PWM_CAPTURE_TIMEOUT_EN
            ST_STUCK: begin
               if (rise_q) begin
                  stuck_d = 1'b0;
                  state_d = ST_MEASURE;
               end
            end
`endif
            default: state_d = ST_ARM;
         endcase
`ifdef PWM_CAPTURE_TIMEOUT_EN
         if (timeout && (state_q != ST_STUCK)) begin
            state_d = ST_STUCK;
            stuck_d = 1'b1;
            stl_d   = hist_q;
            valid_d = 1'b0;
         end
`endif
      end

      assign hi_arr[c]  = hi_q;
      assign per_arr[c] = per_q;
      assign pulse_v[c] = pulse_q;
      assign valid_v[c] = valid_q;
`ifdef PWM_CAPTURE_TIMEOUT_EN
      assign stuck_v[c] = stuck_q;
      assign stl_v[c]   = stl_q;
`endif
   end

   // Selector only steers registered results; measurement never sees it
   always_comb begin
      bus.high_count   = '0;
      bus.period_count = '0;
      case (bus.color_selector)
         2'b00: begin bus.high_count = hi_arr[0]; bus.period_count = per_arr[0]; end
         2'b01: begin bus.high_count = hi_arr[1]; bus.period_count = per_arr[1]; end
         2'b10: begin bus.high_count = hi_arr[2]; bus.period_count = per_arr[2]; end
         default: ;
      endcase
   end

   assign bus.sample_pulse = pulse_v;
   assign bus.valid        = valid_v;
`ifdef PWM_CAPTURE_TIMEOUT_EN
   assign bus.stuck        = stuck_v;
   assign bus.stuck_level  = stl_v;
`else
   assign bus.stuck        = 3'b000;
   assign bus.stuck_level  = 3'b000;
`endif
endmodule

// File: tb/tb_rgb_pwm_capture.sv
// Bench for rgb_pwm_capture: sample-level reference model compared every cycle,
// plus directed PWM scenarios with literal expected results.
module tb_rgb_pwm_capture;
   localparam int R       = 8;
   localparam int W       = 16;
   localparam int MAXV    = (1 << W) - 1;
   localparam int TIMEOUT = 2**(R+4);

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   rgb_pwm_capture_if #(.W(W)) bus ();

   rgb_pwm_capture #(.R(R), .W(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
   endtask

   // Stimulus generators: per[c]==0 means static level stat[c]
   int   per [3];
   int   hi  [3];
   int   ph  [3];
   logic stat[3];
   bit   tog = 1'b0;

   task automatic step(input int n);
      logic [2:0] lv;
      repeat (n) begin
         @(posedge clk);
         #1;
         for (int c = 0; c < 3; c++) begin
            lv[c] = (per[c] == 0) ? stat[c] : (ph[c] < hi[c]);
            if (per[c] != 0) ph[c] = (ph[c] + 1) % per[c];
         end
         bus.red_in   = lv[0];
         bus.green_in = lv[1];
         bus.blue_in  = lv[2];
         if (tog) bus.color_selector = bus.color_selector + 2'd1;
      end
   endtask

   // Reference model: every input sample reaches the measurement three edges later
   int         m_p [3];
   int         m_h [3];
   int         m_st[3];
   int         m_per[3];
   int         m_hi [3];
   logic [3:0] m_sh[3];
   logic [2:0] m_pulse, m_valid, m_stuck, m_stl;
   bit         m_ok = 1'b0;

   always @(posedge clk) begin
      logic [2:0] raw;
      raw = {bus.blue_in, bus.green_in, bus.red_in};
      if (reset) begin
         for (int c = 0; c < 3; c++) begin
            m_p[c] = 0; m_h[c] = 0; m_st[c] = 0; m_per[c] = 0; m_hi[c] = 0; m_sh[c] = 4'b0;
         end
         m_pulse = 3'b0; m_valid = 3'b0; m_stuck = 3'b0; m_stl = 3'b0;
         m_ok = 1'b1;
      end else if (m_ok) begin
         for (int c = 0; c < 3; c++) begin
            logic v, pv;
            v  = m_sh[c][2];
            pv = m_sh[c][3];
            m_sh[c] = {m_sh[c][2:0], raw[c]};
            m_pulse[c] = 1'b0;
            if (v && !pv) begin
               if (m_st[c] == 1) begin
                  m_per[c] = m_p[c]; m_hi[c] = m_h[c]; m_pulse[c] = 1'b1; m_valid[c] = 1'b1;
               end
               m_st[c] = 1; m_stuck[c] = 1'b0; m_p[c] = 1; m_h[c] = 1;
            end else begin
               m_p[c] = (m_p[c] >= MAXV) ? MAXV : m_p[c] + 1;
               if (v) m_h[c] = (m_h[c] >= MAXV) ? MAXV : m_h[c] + 1;
`ifdef PWM_CAPTURE_TIMEOUT_EN
               if (m_st[c] != 2 && m_p[c] == TIMEOUT) begin
                  m_st[c] = 2; m_stuck[c] = 1'b1; m_stl[c] = v; m_valid[c] = 1'b0;
               end
`endif
            end
         end
      end
   end

   int pcnt[3];
   int triple = 0;

   always @(negedge clk) begin
      logic [W-1:0] eh, ep;
      if (m_ok) begin
         eh = '0; ep = '0;
         if (bus.color_selector != 2'b11) begin
            eh = W'(m_hi[bus.color_selector]);
            ep = W'(m_per[bus.color_selector]);
         end
         chk("cycle",
             {bus.high_count, bus.period_count, bus.sample_pulse, bus.valid, bus.stuck, bus.stuck_level},
             {eh, ep, m_pulse, m_valid, m_stuck, m_stl});
         for (int c = 0; c < 3; c++) pcnt[c] += int'(bus.sample_pulse[c]);
         if (bus.sample_pulse == 3'b111) triple++;
      end
   end

   task automatic clr_cnt();
      for (int c = 0; c < 3; c++) pcnt[c] = 0;
      triple = 0;
   endtask

   initial begin
      bus.red_in = 1'b0; bus.green_in = 1'b0; bus.blue_in = 1'b0;
      bus.color_selector = 2'b00;
      for (int c = 0; c < 3; c++) begin per[c] = 0; hi[c] = 0; ph[c] = 0; stat[c] = 1'b0; pcnt[c] = 0; end

      reset = 1'b1;
      step(3);
      chk("reset_outputs",
          {bus.high_count, bus.period_count, bus.sample_pulse, bus.valid, bus.stuck, bus.stuck_level}, 64'd0);
      reset = 1'b0;

      // red 256/64
      clr_cnt();
      per[0] = 256; hi[0] = 64; ph[0] = 0;
      step(5 * 256);
      chk("red_high", bus.high_count, 64'd64);
      chk("red_period", bus.period_count, 64'd256);
      chk("red_valid", bus.valid, 64'b001);
      chk("red_pulses", pcnt[0], 64'd4);

      // selector toggled every cycle
      clr_cnt();
      tog = 1'b1;
      step(1024);
      tog = 1'b0;
      bus.color_selector = 2'b00;
      #1;
      chk("tog_pulses", pcnt[0], 64'd4);
      chk("tog_high", bus.high_count, 64'd64);
      chk("tog_period", bus.period_count, 64'd256);

      // three aligned channels, period 512
      clr_cnt();
      for (int c = 0; c < 3; c++) begin per[c] = 512; ph[c] = 0; end
      hi[0] = 128; hi[1] = 256; hi[2] = 511;
      step(3 * 512);
      chk("aligned_triple_pulses", triple, 64'd2);
      chk("aligned_valid", bus.valid, 64'b111);
      bus.color_selector = 2'b00; #1;
      chk("sel0", {bus.high_count, bus.period_count}, {16'd128, 16'd512});
      bus.color_selector = 2'b01; #1;
      chk("sel1", {bus.high_count, bus.period_count}, {16'd256, 16'd512});
      bus.color_selector = 2'b10; #1;
      chk("sel2", {bus.high_count, bus.period_count}, {16'd511, 16'd512});
      bus.color_selector = 2'b11; #1;
      chk("sel3", {bus.high_count, bus.period_count}, 64'd0);
      bus.color_selector = 2'b00;

      // reset pulse in the middle of a red period
      per[1] = 0; per[2] = 0; stat[1] = 1'b0; stat[2] = 1'b0;
      per[0] = 256; hi[0] = 64; ph[0] = 0;
      step(400);
      reset = 1'b1;
      step(1);
      chk("midreset_outputs",
          {bus.high_count, bus.period_count, bus.sample_pulse, bus.valid, bus.stuck, bus.stuck_level}, 64'd0);
      reset = 1'b0;
      clr_cnt();
      step(500);
      chk("midreset_pulses", pcnt[0], 64'd1);
      chk("midreset_result", {bus.high_count, bus.period_count}, {16'd64, 16'd256});
      chk("midreset_valid", bus.valid, 64'b001);

`ifdef PWM_CAPTURE_TIMEOUT_EN
      // green goes stuck high, then resumes 100/30
      per[1] = 100; hi[1] = 30; ph[1] = 0;
      step(300);
      per[1] = 0; stat[1] = 1'b1;
      step(TIMEOUT + 100);
      chk("stuck_green", bus.stuck[1], 64'd1);
      chk("stuck_level_green", bus.stuck_level[1], 64'd1);
      chk("stuck_valid_green", bus.valid[1], 64'd0);
      chk("stuck_blue_low", {bus.stuck[2], bus.stuck_level[2]}, 64'b10);
      per[1] = 100; hi[1] = 30; ph[1] = 0;
      step(350);
      bus.color_selector = 2'b01; #1;
      chk("resume_stuck", bus.stuck[1], 64'd0);
      chk("resume_valid", bus.valid[1], 64'd1);
      chk("resume_result", {bus.high_count, bus.period_count}, {16'd30, 16'd100});
`else
      // blue single pulse, long idle, then a rise: saturated period
      clr_cnt();
      stat[2] = 1'b1; step(10);
      stat[2] = 1'b0; step((1 << W) + 100);
      stat[2] = 1'b1; step(10);
      stat[2] = 1'b0; step(10);
      bus.color_selector = 2'b10; #1;
      chk("sat_period", bus.period_count, 64'(MAXV));
      chk("sat_high", bus.high_count, 64'd10);
      chk("sat_pulses", pcnt[2], 64'd1);
      chk("sat_stuck_off", {bus.stuck, bus.stuck_level}, 64'd0);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
